argmax_clasificator: RTL
========================

Name: argmax_clasificator

Overview:
- Result stage behind the final dense/ReLU layer: consumer side of its `layer_terminat` / output-vector interface.
- On each new completion of the output layer, snapshots the class scores and scans them sequentially, one comparison per cycle.
- Presents the winning class index and score through a valid/ready handshake to the downstream consumer (display or UART reporter).

Parameters:
- NUMAR_CLASE, 10, number of class scores in the input vector (≥2).
- LATIME, 16, width of each signed score.
- IDX_W, 4, width of the class index; must satisfy 2^IDX_W ≥ NUMAR_CLASE.

Ports:
- clock  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- layer_terminat  input  1  completion level from the output layer; a rising edge starts classification.
- date_intrare  input  signed LATIME x [0:NUMAR_CLASE-1]  class scores; valid whenever layer_terminat is high.
- cifra_out  output  IDX_W  index of the maximum score.
- scor_out  output  signed LATIME  the maximum score.
- rezultat_valid  output  1  result available; held until accepted.
- rezultat_ready  input  1  downstream accepts the result when high together with rezultat_valid.
- ocupat  output  1  high in SCAN and DONE.
- pierdut  output  1  one-cycle pulse when a start edge is dropped.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE.
  - All outputs 0, snapshot 0, pointer 0.
  - Edge register (previous layer_terminat) = 0, so a level still high after reset release counts as a new start.
- Start detection: start = layer_terminat & ~prev. prev is updated every cycle in every state.
- IDLE, on start:
  - snapshot ← date_intrare; best ← date_intrare[0]; best_idx ← 0; ptr ← 1.
  - Next state SCAN; ocupat=1 from the next cycle.
- SCAN, each cycle:
  - If snapshot[ptr] > best (signed, strict), then best ← snapshot[ptr] and best_idx ← ptr.
  - ptr ← ptr+1.
  - When ptr==NUMAR_CLASE-1 has been compared, go to DONE and register cifra_out/scor_out.
- DONE:
  - rezultat_valid=1; cifra_out and scor_out stable.
  - On rezultat_valid & rezultat_ready, go to IDLE; rezultat_valid drops the next cycle.
  - cifra_out and scor_out retain their last values in IDLE.
- Latency: start sampled at edge k → rezultat_valid high after edge k+NUMAR_CLASE-1, i.e. 9 cycles for the default.
- Ties: the lowest index wins because the comparison is strict.
- Signed arithmetic throughout. Negative scores are handled correctly even though the ReLU upstream yields values ≥0.
- Start while in SCAN or DONE: ignored, pierdut pulses for one cycle, snapshot unchanged.
- Start in the same cycle as a DONE handshake: dropped (pierdut=1). A new start requires a fresh rising edge.
- Input changes after capture have no effect; only the snapshot is used.
- Reset mid-SCAN or mid-DONE: immediate return to IDLE; the pending result is discarded.

Optional Feature:
- Macro: ARGMAX_MARGINE_EN.
- Defined:
  - Adds output port `margine` (unsigned, LATIME+1 bits).
  - The block also tracks the second-best score; margine = best − second_best, registered with cifra_out.
  - Initialisation: second_best ← most-negative LATIME value at capture.
  - When a new best is found, the old best moves to second_best. Otherwise second_best updates if snapshot[ptr] > second_best.
  - A tie with best gives margine=0.
- Undefined: port and second-best logic are absent. Latency and all other behaviour are identical.

Decomposition:
- Shared package nn_pkg:
  - NUMAR_CLASE and LATIME constants.
  - Signed score typedef.
  - Class index typedef.
  - Enum stare_argmax_t {IDLE, SCAN, DONE}.
- One sub-module, detector_front: synchronous rising-edge detector with active-low sync reset, reused for the start and pierdut logic.

Test Plan:
- Scores {5,3,90,2,0,7,1,4,6,8}, raise layer_terminat → rezultat_valid after 9 cycles, cifra_out=2, scor_out=90; margine=82 if enabled.
- Scores {0,...,0,40,40} (indices 8,9) → cifra_out=8, scor_out=40; margine=0.
- Hold rezultat_ready=0 for 20 cycles → valid and outputs stable. Then ready=1 for one cycle → valid low next cycle, ocupat=0.
- Second start edge (layer_terminat low then high) 3 cycles into SCAN → pierdut one-cycle pulse, result is still the first vector.
- Scores all negative {−7,−3,−9,...,−20} → cifra_out=1, scor_out=−3.
- Reset low at SCAN cycle 4 → next cycle all outputs 0, state IDLE. With layer_terminat held high through reset, a new classification starts after release.

Source files
------------

// File: rtl/nn_pkg.sv
// ---------------------------------------------------------------------------
// nn_pkg: shared constants and types for the network result stage. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package nn_pkg;

   localparam int NUMAR_CLASE = 10;
   localparam int LATIME      = 16;
   localparam int IDX_W       = 4;

   typedef logic signed [LATIME-1:0] scor_t;
   typedef logic [IDX_W-1:0]         index_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } stare_argmax_t;

endpackage

`default_nettype wire

// File: rtl/argmax_clasificator_detector_front.sv
// ---------------------------------------------------------------------------
// detector_front: synchronous rising-edge detector, active-low sync reset. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module detector_front (
   input  logic clock,
   input  logic reset,
   input  logic nivel,
   output logic front
);

   logic r_anterior;

   // Cleared on reset so a level already high after release reads as an edge.
   always_ff @(posedge clock) begin
      if (!reset) r_anterior <= 1'b0;
      else        r_anterior <= nivel;
   end

   assign front = nivel & ~r_anterior;

endmodule

`default_nettype wire

// File: rtl/argmax_clasificator.sv
// ---------------------------------------------------------------------------
// argmax_clasificator: sequential argmax of class scores, optional ARGMAX_MARGINE_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module argmax_clasificator
   import nn_pkg::*;
#(
   parameter int NUMAR_CLASE = nn_pkg::NUMAR_CLASE,
   parameter int LATIME      = nn_pkg::LATIME,
   parameter int IDX_W       = nn_pkg::IDX_W
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     layer_terminat,
   input  logic signed [LATIME-1:0] date_intrare [0:NUMAR_CLASE-1],
   output logic [IDX_W-1:0]         cifra_out,
   output logic signed [LATIME-1:0] scor_out,
`ifdef ARGMAX_MARGINE_EN
   output logic [LATIME:0]          margine,
`endif
   output logic                     rezultat_valid,
   input  logic                     rezultat_ready,
   output logic                     ocupat,
   output logic                     pierdut
);

   localparam logic [IDX_W-1:0] C_ULTIM = IDX_W'(NUMAR_CLASE-1);

   stare_argmax_t            stare;
   logic signed [LATIME-1:0] snapshot [0:NUMAR_CLASE-1];
   logic signed [LATIME-1:0] r_best;
   logic signed [LATIME-1:0] w_val;
   logic signed [LATIME-1:0] w_best_nou;
   logic [IDX_W-1:0]         r_best_idx;
   logic [IDX_W-1:0]         w_idx_nou;
   logic [IDX_W-1:0]         r_ptr;
   logic                     w_start;

   detector_front u_start (
      .clock (clock),
      .reset (reset),
      .nivel (layer_terminat),
      .front (w_start)
   );

   // Strict compare keeps the lowest index on ties.
   always_comb begin
      w_val      = snapshot[r_ptr];
      w_best_nou = r_best;
      w_idx_nou  = r_best_idx;
      if (w_val > r_best) begin
         w_best_nou = w_val;
         w_idx_nou  = r_ptr;
      end
   end

`ifdef ARGMAX_MARGINE_EN
   logic signed [LATIME-1:0] r_second;
   logic signed [LATIME-1:0] w_second_nou;
   logic [LATIME:0]          w_diferenta;

   always_comb begin
      w_second_nou = r_second;
      if (w_val > r_best)
         w_second_nou = r_best;
      else if (w_val > r_second)
         w_second_nou = w_val;
      w_diferenta = {w_best_nou[LATIME-1], w_best_nou} - {w_second_nou[LATIME-1], w_second_nou};
   end
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         stare          <= IDLE;
         cifra_out      <= '0;
         scor_out       <= '0;
         rezultat_valid <= 1'b0;
         ocupat         <= 1'b0;
         pierdut        <= 1'b0;
         r_best         <= '0;
         r_best_idx     <= '0;
         r_ptr          <= '0;
         for (int i = 0; i < NUMAR_CLASE; i++) snapshot[i] <= '0;
`ifdef ARGMAX_MARGINE_EN
         r_second       <= '0;
         margine        <= '0;
`endif
      end else begin
         pierdut <= w_start && (stare != IDLE);
         case (stare)
            IDLE: begin
               if (w_start) begin
                  snapshot   <= date_intrare;
                  r_best     <= date_intrare[0];
                  r_best_idx <= '0;
                  r_ptr      <= IDX_W'(1);
                  ocupat     <= 1'b1;
                  stare      <= SCAN;
`ifdef ARGMAX_MARGINE_EN
                  r_second   <= {1'b1, {(LATIME-1){1'b0}}};
`endif
               end
            end
            SCAN: begin
               r_best     <= w_best_nou;
               r_best_idx <= w_idx_nou;
               r_ptr      <= r_ptr + 1'b1;
`ifdef ARGMAX_MARGINE_EN
               r_second   <= w_second_nou;
`endif
               if (r_ptr == C_ULTIM) begin
                  cifra_out      <= w_idx_nou;
                  scor_out       <= w_best_nou;
                  rezultat_valid <= 1'b1;
                  stare          <= DONE;
`ifdef ARGMAX_MARGINE_EN
                  margine        <= w_diferenta;
`endif
               end
            end
            DONE: begin
               if (rezultat_ready) begin
                  rezultat_valid <= 1'b0;
                  ocupat         <= 1'b0;
                  stare          <= IDLE;
               end
            end
            default: stare <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
